// File: rtl/dcache_loadpipe_nway_if.sv
// Bus bundle between the load pipeline and its neighbours: load unit, tag array,
// TLB response, MSHR allocation port, completion port and perf counters.
interface dcache_loadpipe_nway_if #(
    parameter int WAY_NUM     = 4,
    parameter int VADDR_WIDTH = 39,
    parameter int PADDR_WIDTH = 36,
    parameter int IDX_HIGH    = 11,
    parameter int IDX_LOW     = 6,
    parameter int ROBID_WIDTH = 7,
    parameter int CNT_WIDTH   = 16
);
    localparam int TAGARRAY_ADDR_WIDTH = IDX_HIGH - IDX_LOW + 1;
    localparam int TAG_WIDTH           = PADDR_WIDTH - IDX_HIGH - 1;
    localparam int TAGARRAY_DATA_WIDTH = TAG_WIDTH + 1;
    localparam int WAY_W               = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    logic                                   req_valid;
    logic                                   req_ready;
    logic [VADDR_WIDTH-1:0]                 req_vaddr;
    logic [ROBID_WIDTH-1:0]                 req_robid;
    logic                                   fromtlb_valid;
    logic                                   fromtlb_hit;
    logic [PADDR_WIDTH-1:0]                 fromtlb_paddr;
    logic                                   tagarray_rd_en;
    logic [TAGARRAY_ADDR_WIDTH-1:0]         tagarray_rd_idx;
    logic [WAY_NUM*TAGARRAY_DATA_WIDTH-1:0] tagarray_rd_data;
    logic                                   mshr_allocate_valid;
    logic                                   mshr_allocate_ready;
    logic [PADDR_WIDTH-1:0]                 mshr_allocate_paddr;
    logic [ROBID_WIDTH-1:0]                 mshr_allocate_robid;
    logic                                   resp_valid;
    logic [ROBID_WIDTH-1:0]                 resp_robid;
    logic                                   resp_hit;
    logic                                   resp_miss;
    logic                                   resp_replay;
    logic                                   resp_multihit;
    logic [WAY_W-1:0]                       resp_way;
    logic [CNT_WIDTH-1:0]                   perf_hit_cnt;
    logic [CNT_WIDTH-1:0]                   perf_miss_cnt;

    modport master (
        output req_valid, req_vaddr, req_robid, fromtlb_valid, fromtlb_hit, fromtlb_paddr,
               tagarray_rd_data, mshr_allocate_ready,
        input  req_ready, tagarray_rd_en, tagarray_rd_idx, mshr_allocate_valid,
               mshr_allocate_paddr, mshr_allocate_robid, resp_valid, resp_robid, resp_hit,
               resp_miss, resp_replay, resp_multihit, resp_way, perf_hit_cnt, perf_miss_cnt
    );

    modport slave (
        input  req_valid, req_vaddr, req_robid, fromtlb_valid, fromtlb_hit, fromtlb_paddr,
               tagarray_rd_data, mshr_allocate_ready,
        output req_ready, tagarray_rd_en, tagarray_rd_idx, mshr_allocate_valid,
               mshr_allocate_paddr, mshr_allocate_robid, resp_valid, resp_robid, resp_hit,
               resp_miss, resp_replay, resp_multihit, resp_way, perf_hit_cnt, perf_miss_cnt
    );
endinterface

// File: rtl/dcache_loadpipe_nway.sv
// Three-stage N-way dcache load pipeline: S0 tag read, S1 tag compare with TLB merge
// (result held across stalls), S2 hit/replay completion or MSHR allocation for misses.
module dcache_loadpipe_nway #(
    parameter int WAY_NUM     = 4,
    parameter int VADDR_WIDTH = 39,
    parameter int PADDR_WIDTH = 36,
    parameter int IDX_HIGH    = 11,
    parameter int IDX_LOW     = 6,
    parameter int ROBID_WIDTH = 7,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    dcache_loadpipe_nway_if.slave        bus
);
    localparam int TAG_WIDTH = PADDR_WIDTH - IDX_HIGH - 1;
    localparam int DW        = TAG_WIDTH + 1;
    localparam int WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam int LINE_W    = PADDR_WIDTH - IDX_LOW;

    function automatic logic [3:0] popcount(input logic [WAY_NUM-1:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < WAY_NUM; i++) c = c + 4'(m[i]);
        return c;
    endfunction

    function automatic logic [WAY_W-1:0] first_way(input logic [WAY_NUM-1:0] m);
        logic [WAY_W-1:0] w;
        w = {WAY_W{1'b0}};
        for (int i = WAY_NUM - 1; i >= 0; i--) w = m[i] ? WAY_W'(i) : w;
        return w;
    endfunction

    logic                   s1_valid_q, s1_fresh_q, s2_valid_q;
    logic [ROBID_WIDTH-1:0] s1_robid_q, s2_robid_q;
    logic                   s1h_hit_q, s1h_miss_q, s1h_replay_q, s1h_multi_q;
    logic [WAY_W-1:0]       s1h_way_q, s2_way_q;
    logic [LINE_W-1:0]      s1h_line_q, s2_line_q;
    logic                   s2_hit_q, s2_miss_q, s2_replay_q, s2_multi_q;
    logic [CNT_WIDTH-1:0]   hit_cnt_q, miss_cnt_q;

    logic [WAY_NUM-1:0]     match_s;
    logic [TAG_WIDTH-1:0]   tag_cmp_s;
    logic                   f_replay_s, f_hit_s, f_miss_s, f_multi_s;
    logic [WAY_W-1:0]       f_way_s;
    logic                   sel_hit_s, sel_miss_s, sel_replay_s, sel_multi_s;
    logic [WAY_W-1:0]       sel_way_s;
    logic [LINE_W-1:0]      sel_line_s;
    logic                   mshr_valid_s, s2_adv_s, s1_adv_s, req_ready_s, accept_s, resp_valid_s;
    logic                   unused_s;

    // S1 only needs the translated address; the untranslated vaddr beyond the index is dead here.
    assign unused_s = ^{bus.req_vaddr[VADDR_WIDTH-1:IDX_HIGH+1], bus.req_vaddr[IDX_LOW-1:0],
                        bus.fromtlb_paddr[IDX_LOW-1:0]};

    assign tag_cmp_s = bus.fromtlb_paddr[PADDR_WIDTH-1:IDX_HIGH+1];
    for (genvar g = 0; g < WAY_NUM; g++) begin : g_match
        assign match_s[g] = bus.tagarray_rd_data[g*DW + TAG_WIDTH]
                          & (bus.tagarray_rd_data[g*DW +: TAG_WIDTH] == tag_cmp_s);
    end

    // Fresh compare result from this cycle's tag/TLB inputs
    always_comb begin
        f_replay_s = ~bus.fromtlb_valid | ~bus.fromtlb_hit;
        f_hit_s    = (|match_s) & ~f_replay_s;
        f_miss_s   = ~(|match_s) & ~f_replay_s;
        f_multi_s  = f_hit_s & (popcount(match_s) > 4'd1);
        if (f_hit_s) begin
            f_way_s = first_way(match_s);
        end else begin
            f_way_s = {WAY_W{1'b0}};
        end
    end

    // Tag/TLB inputs are only meaningful on the first S1 cycle; afterwards use held copies.
    assign sel_hit_s    = s1_fresh_q ? f_hit_s    : s1h_hit_q;
    assign sel_miss_s   = s1_fresh_q ? f_miss_s   : s1h_miss_q;
    assign sel_replay_s = s1_fresh_q ? f_replay_s : s1h_replay_q;
    assign sel_multi_s  = s1_fresh_q ? f_multi_s  : s1h_multi_q;
    assign sel_way_s    = s1_fresh_q ? f_way_s    : s1h_way_q;
    assign sel_line_s   = s1_fresh_q ? bus.fromtlb_paddr[PADDR_WIDTH-1:IDX_LOW] : s1h_line_q;

    assign mshr_valid_s = s2_valid_q & s2_miss_q & ~flush_i;
    assign s2_adv_s     = (s2_valid_q & (s2_hit_q | s2_replay_q)) | (mshr_valid_s & bus.mshr_allocate_ready);
    assign s1_adv_s     = s1_valid_q & (~s2_valid_q | s2_adv_s);
    assign req_ready_s  = ~flush_i & (~s1_valid_q | s1_adv_s);
    assign accept_s     = bus.req_valid & req_ready_s;
    assign resp_valid_s = s2_adv_s & ~flush_i;

    assign bus.req_ready           = req_ready_s;
    assign bus.tagarray_rd_en      = accept_s;
    assign bus.tagarray_rd_idx     = bus.req_vaddr[IDX_HIGH:IDX_LOW];
    assign bus.mshr_allocate_valid = mshr_valid_s;
    assign bus.mshr_allocate_paddr = {s2_line_q, {IDX_LOW{1'b0}}};
    assign bus.mshr_allocate_robid = s2_robid_q;
    assign bus.resp_valid          = resp_valid_s;
    assign bus.resp_robid          = resp_valid_s ? s2_robid_q : {ROBID_WIDTH{1'b0}};
    assign bus.resp_hit            = resp_valid_s & s2_hit_q;
    assign bus.resp_miss           = resp_valid_s & s2_miss_q;
    assign bus.resp_replay         = resp_valid_s & s2_replay_q;
    assign bus.resp_multihit       = resp_valid_s & s2_hit_q & s2_multi_q;
    assign bus.resp_way            = (resp_valid_s & s2_hit_q) ? s2_way_q : {WAY_W{1'b0}};
    assign bus.perf_hit_cnt        = hit_cnt_q;
    assign bus.perf_miss_cnt       = miss_cnt_q;

    // Stage valids, S1 capture and hold, S2 payload transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_fresh_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_robid_q   <= {ROBID_WIDTH{1'b0}};
            s2_robid_q   <= {ROBID_WIDTH{1'b0}};
            s1h_hit_q    <= 1'b0;
            s1h_miss_q   <= 1'b0;
            s1h_replay_q <= 1'b0;
            s1h_multi_q  <= 1'b0;
            s1h_way_q    <= {WAY_W{1'b0}};
            s1h_line_q   <= {LINE_W{1'b0}};
            s2_hit_q     <= 1'b0;
            s2_miss_q    <= 1'b0;
            s2_replay_q  <= 1'b0;
            s2_multi_q   <= 1'b0;
            s2_way_q     <= {WAY_W{1'b0}};
            s2_line_q    <= {LINE_W{1'b0}};
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
            s1_fresh_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_q <= 1'b1;
                s1_fresh_q <= 1'b1;
                s1_robid_q <= bus.req_robid;
            end else if (s1_adv_s) begin
                s1_valid_q <= 1'b0;
                s1_fresh_q <= 1'b0;
            end else begin
                s1_fresh_q <= 1'b0;
            end
            if (s1_fresh_q) begin
                s1h_hit_q    <= f_hit_s;
                s1h_miss_q   <= f_miss_s;
                s1h_replay_q <= f_replay_s;
                s1h_multi_q  <= f_multi_s;
                s1h_way_q    <= f_way_s;
                s1h_line_q   <= bus.fromtlb_paddr[PADDR_WIDTH-1:IDX_LOW];
            end
            if (s1_adv_s) begin
                s2_valid_q  <= 1'b1;
                s2_robid_q  <= s1_robid_q;
                s2_hit_q    <= sel_hit_s;
                s2_miss_q   <= sel_miss_s;
                s2_replay_q <= sel_replay_s;
                s2_multi_q  <= sel_multi_s;
                s2_way_q    <= sel_way_s;
                s2_line_q   <= sel_line_s;
            end else if (s2_adv_s) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    // Saturating hit/miss counters; flush leaves them alone
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= {CNT_WIDTH{1'b0}};
            miss_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            if (bus.resp_hit && (hit_cnt_q != {CNT_WIDTH{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end
            if (bus.resp_miss && (miss_cnt_q != {CNT_WIDTH{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_dcache_loadpipe_nway.sv
// Directed bench for dcache_loadpipe_nway (4 ways, 2-bit perf counters): single-load
// vector table, then miss stall with back-to-back load, flush, async reset and streaming hits.
module tb_dcache_loadpipe_nway;
    localparam int DW = 25;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    dcache_loadpipe_nway_if #(.CNT_WIDTH(2)) bus();
    dcache_loadpipe_nway #(.CNT_WIDTH(2)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    typedef struct {
        logic [4*DW-1:0] tags;
        logic            tlb_v;
        logic            tlb_h;
        logic [35:0]     paddr;
        logic [6:0]      robid;
        logic            e_hit;
        logic            e_miss;
        logic            e_rep;
        logic            e_mh;
        logic [1:0]      e_way;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hit_m    = 0;
    int   miss_m   = 0;

    localparam logic [23:0] T  = 24'h001234;
    localparam logic [23:0] T2 = 24'h001235;
    localparam logic [23:0] T3 = 24'hABCDEF;
    localparam logic [38:0] VA = 39'h140;

    function automatic logic [DW-1:0] ent(input logic v, input logic [23:0] t);
        return {v, t};
    endfunction

    function automatic logic [35:0] pa(input logic [23:0] t);
        return {t, 6'd5, 6'h2A};
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s1(input logic [4*DW-1:0] tags, input logic v, input logic h, input logic [35:0] p);
        bus.tagarray_rd_data = tags;
        bus.fromtlb_valid    = v;
        bus.fromtlb_hit      = h;
        bus.fromtlb_paddr    = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [35:0] ep;
        bus.req_valid = 1'b0;
        bus.req_vaddr = VA;
        bus.req_robid = 7'd0;
        bus.mshr_allocate_ready = 1'b0;
        drive_s1('0, 1'b0, 1'b0, 36'd0);

        vecs[0] = '{tags: {ent(1'b0,T), ent(1'b1,T), ent(1'b0,T), ent(1'b0,T)}, tlb_v: 1'b1, tlb_h: 1'b1,
                    paddr: pa(T),  robid: 7'd1, e_hit: 1'b1, e_miss: 1'b0, e_rep: 1'b0, e_mh: 1'b0, e_way: 2'd2};
        vecs[1] = '{tags: {ent(1'b1,T), ent(1'b0,T), ent(1'b1,T), ent(1'b1,T2)}, tlb_v: 1'b1, tlb_h: 1'b1,
                    paddr: pa(T),  robid: 7'd2, e_hit: 1'b1, e_miss: 1'b0, e_rep: 1'b0, e_mh: 1'b1, e_way: 2'd1};
        vecs[2] = '{tags: {ent(1'b1,T2), ent(1'b1,T2), ent(1'b0,T), ent(1'b1,T2)}, tlb_v: 1'b1, tlb_h: 1'b1,
                    paddr: pa(T),  robid: 7'd3, e_hit: 1'b0, e_miss: 1'b1, e_rep: 1'b0, e_mh: 1'b0, e_way: 2'd0};
        vecs[3] = '{tags: {ent(1'b0,T), ent(1'b0,T), ent(1'b0,T), ent(1'b1,T)}, tlb_v: 1'b1, tlb_h: 1'b0,
                    paddr: pa(T),  robid: 7'd4, e_hit: 1'b0, e_miss: 1'b0, e_rep: 1'b1, e_mh: 1'b0, e_way: 2'd0};
        vecs[4] = '{tags: {ent(1'b0,T), ent(1'b0,T), ent(1'b0,T), ent(1'b1,T)}, tlb_v: 1'b0, tlb_h: 1'b1,
                    paddr: pa(T),  robid: 7'd5, e_hit: 1'b0, e_miss: 1'b0, e_rep: 1'b1, e_mh: 1'b0, e_way: 2'd0};
        vecs[5] = '{tags: {ent(1'b1,T), ent(1'b1,T), ent(1'b1,T), ent(1'b1,T)}, tlb_v: 1'b1, tlb_h: 1'b1,
                    paddr: pa(T),  robid: 7'd6, e_hit: 1'b1, e_miss: 1'b0, e_rep: 1'b0, e_mh: 1'b1, e_way: 2'd0};
        vecs[6] = '{tags: {ent(1'b1,T), ent(1'b0,T), ent(1'b0,T), ent(1'b0,T)}, tlb_v: 1'b1, tlb_h: 1'b1,
                    paddr: pa(T),  robid: 7'd7, e_hit: 1'b1, e_miss: 1'b0, e_rep: 1'b0, e_mh: 1'b0, e_way: 2'd3};
        vecs[7] = '{tags: {ent(1'b0,T), ent(1'b0,T), ent(1'b0,T), ent(1'b1,T)}, tlb_v: 1'b1, tlb_h: 1'b1,
                    paddr: pa(T3), robid: 7'd8, e_hit: 1'b0, e_miss: 1'b1, e_rep: 1'b0, e_mh: 1'b0, e_way: 2'd0};

        // Reset values while rst_n is held low
        #3;
        check("rst_req_ready",  64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_mshr_valid", 64'(bus.mshr_allocate_valid), 64'd0);
        check("rst_perf_hit",   64'(bus.perf_hit_cnt), 64'd0);
        check("rst_perf_miss",  64'(bus.perf_miss_cnt), 64'd0);
        #9;
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_robid = vecs[i].robid;
            #1;
            check("v_req_ready", 64'(bus.req_ready), 64'd1);
            check("v_rd_en",     64'(bus.tagarray_rd_en), 64'd1);
            check("v_rd_idx",    64'(bus.tagarray_rd_idx), 64'd5);
            tick;
            bus.req_valid = 1'b0;
            drive_s1(vecs[i].tags, vecs[i].tlb_v, vecs[i].tlb_h, vecs[i].paddr);
            #1;
            check("v_resp_early", 64'(bus.resp_valid), 64'd0);
            tick;
            drive_s1('0, 1'b0, 1'b0, 36'd0);
            bus.mshr_allocate_ready = 1'b1;
            #1;
            check("v_resp_valid", 64'(bus.resp_valid), 64'd1);
            check("v_resp_hit",   64'(bus.resp_hit), 64'(vecs[i].e_hit));
            check("v_resp_miss",  64'(bus.resp_miss), 64'(vecs[i].e_miss));
            check("v_resp_rep",   64'(bus.resp_replay), 64'(vecs[i].e_rep));
            check("v_resp_mh",    64'(bus.resp_multihit), 64'(vecs[i].e_mh));
            check("v_resp_way",   64'(bus.resp_way), 64'(vecs[i].e_way));
            check("v_resp_robid", 64'(bus.resp_robid), 64'(vecs[i].robid));
            check("v_mshr_valid", 64'(bus.mshr_allocate_valid), 64'(vecs[i].e_miss));
            if (vecs[i].e_miss) begin
                ep = vecs[i].paddr;
                ep[5:0] = 6'd0;
                check("v_mshr_paddr", 64'(bus.mshr_allocate_paddr), 64'(ep));
                check("v_mshr_robid", 64'(bus.mshr_allocate_robid), 64'(vecs[i].robid));
            end
            hit_m  += int'(vecs[i].e_hit);
            miss_m += int'(vecs[i].e_miss);
            tick;
            bus.mshr_allocate_ready = 1'b0;
            #1;
            check("v_resp_done", 64'(bus.resp_valid), 64'd0);
            check("v_perf_hit",  64'(bus.perf_hit_cnt), 64'(sat3(hit_m)));
            check("v_perf_miss", 64'(bus.perf_miss_cnt), 64'(sat3(miss_m)));
        end

        // Miss stalled in S2 for 3 cycles with a hit load waiting in S1
        bus.req_valid = 1'b1;
        bus.req_robid = 7'd10;
        #1;
        tick;
        bus.req_robid = 7'd11;
        drive_s1(vecs[0].tags, 1'b1, 1'b1, pa(T3));
        #1;
        check("st_b2b_ready", 64'(bus.req_ready), 64'd1);
        tick;
        bus.req_robid = 7'd12;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive_s1(vecs[0].tags, 1'b1, 1'b1, pa(T));
            else        drive_s1('0, 1'b0, 1'b0, 36'd0);
            #1;
            check("st_mshr_valid", 64'(bus.mshr_allocate_valid), 64'd1);
            check("st_mshr_paddr", 64'(bus.mshr_allocate_paddr), 64'({T3, 6'd5, 6'd0}));
            check("st_mshr_robid", 64'(bus.mshr_allocate_robid), 64'd10);
            check("st_resp_valid", 64'(bus.resp_valid), 64'd0);
            check("st_req_ready",  64'(bus.req_ready), 64'd0);
            tick;
        end
        bus.req_valid = 1'b0;
        bus.mshr_allocate_ready = 1'b1;
        #1;
        check("st_hs_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("st_hs_resp_miss",  64'(bus.resp_miss), 64'd1);
        check("st_hs_robid",      64'(bus.resp_robid), 64'd10);
        check("st_hs_ready",      64'(bus.req_ready), 64'd1);
        miss_m++;
        tick;
        bus.mshr_allocate_ready = 1'b0;
        #1;
        check("st_n_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("st_n_resp_hit",   64'(bus.resp_hit), 64'd1);
        check("st_n_resp_way",   64'(bus.resp_way), 64'd2);
        check("st_n_robid",      64'(bus.resp_robid), 64'd11);
        check("st_n_mshr_valid", 64'(bus.mshr_allocate_valid), 64'd0);
        hit_m++;
        tick;
        check("st_idle",      64'(bus.resp_valid), 64'd0);
        check("st_perf_hit",  64'(bus.perf_hit_cnt), 64'(sat3(hit_m)));
        check("st_perf_miss", 64'(bus.perf_miss_cnt), 64'(sat3(miss_m)));

        // Flush with a miss pending in S2 (MSHR ready high) and a load in S1
        bus.req_valid = 1'b1;
        bus.req_robid = 7'd20;
        #1;
        tick;
        bus.req_robid = 7'd21;
        drive_s1(vecs[0].tags, 1'b1, 1'b1, pa(T3));
        #1;
        tick;
        bus.req_valid = 1'b0;
        drive_s1(vecs[0].tags, 1'b1, 1'b1, pa(T));
        #1;
        check("fl_pre_mshr", 64'(bus.mshr_allocate_valid), 64'd1);
        tick;
        drive_s1('0, 1'b0, 1'b0, 36'd0);
        flush = 1'b1;
        bus.mshr_allocate_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_robid = 7'd22;
        #1;
        check("fl_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("fl_mshr_valid", 64'(bus.mshr_allocate_valid), 64'd0);
        check("fl_req_ready",  64'(bus.req_ready), 64'd0);
        check("fl_rd_en",      64'(bus.tagarray_rd_en), 64'd0);
        tick;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("fl_post_ready", 64'(bus.req_ready), 64'd1);
        check("fl_post_resp",  64'(bus.resp_valid), 64'd0);
        check("fl_post_mshr",  64'(bus.mshr_allocate_valid), 64'd0);
        tick;
        check("fl_post2_resp", 64'(bus.resp_valid), 64'd0);
        check("fl_post2_mshr", 64'(bus.mshr_allocate_valid), 64'd0);
        check("fl_perf_hit",   64'(bus.perf_hit_cnt), 64'(sat3(hit_m)));
        check("fl_perf_miss",  64'(bus.perf_miss_cnt), 64'(sat3(miss_m)));
        bus.mshr_allocate_ready = 1'b0;

        // Asynchronous reset in the middle of an MSHR stall
        bus.req_valid = 1'b1;
        bus.req_robid = 7'd30;
        #1;
        tick;
        bus.req_robid = 7'd31;
        drive_s1(vecs[0].tags, 1'b1, 1'b1, pa(T3));
        #1;
        tick;
        bus.req_valid = 1'b0;
        drive_s1(vecs[0].tags, 1'b1, 1'b1, pa(T));
        #1;
        check("rs_pre_mshr",  64'(bus.mshr_allocate_valid), 64'd1);
        check("rs_pre_ready", 64'(bus.req_ready), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_mshr_valid", 64'(bus.mshr_allocate_valid), 64'd0);
        check("rs_req_ready",  64'(bus.req_ready), 64'd1);
        check("rs_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rs_perf_hit",   64'(bus.perf_hit_cnt), 64'd0);
        check("rs_perf_miss",  64'(bus.perf_miss_cnt), 64'd0);
        #2;
        rst_n = 1'b1;
        hit_m  = 0;
        miss_m = 0;
        drive_s1('0, 1'b0, 1'b0, 36'd0);
        tick;
        check("rs_after_resp", 64'(bus.resp_valid), 64'd0);
        check("rs_after_mshr", 64'(bus.mshr_allocate_valid), 64'd0);

        // Five back-to-back hits: one per cycle, hit counter saturates at 3
        for (int c = 0; c < 7; c++) begin
            bus.req_valid = (c < 5);
            bus.req_robid = 7'(40 + c);
            if (c >= 1 && c <= 5) drive_s1(vecs[6].tags, 1'b1, 1'b1, pa(T));
            else                  drive_s1('0, 1'b0, 1'b0, 36'd0);
            #1;
            if (c < 5) check("bb_ready", 64'(bus.req_ready), 64'd1);
            if (c >= 2) begin
                check("bb_resp_valid", 64'(bus.resp_valid), 64'd1);
                check("bb_resp_hit",   64'(bus.resp_hit), 64'd1);
                check("bb_resp_way",   64'(bus.resp_way), 64'd3);
                check("bb_resp_robid", 64'(bus.resp_robid), 64'(40 + c - 2));
                check("bb_perf_hit",   64'(bus.perf_hit_cnt), 64'(sat3(c - 2)));
            end
            tick;
        end
        check("bb_perf_sat",  64'(bus.perf_hit_cnt), 64'd3);
        check("bb_perf_miss", 64'(bus.perf_miss_cnt), 64'd0);
        check("bb_idle",      64'(bus.resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_loadpipe_nway.md
# dcache_loadpipe_nway

Parametrised three-stage dcache load pipeline (S0 tag read, S1 tag compare and TLB merge, S2 resolve). It replaces the fixed two-level loadpipe. It generalises way count, address and ROB-id widths. It adds full hit/miss resolution, stall-safe result buffering, MSHR allocation with backpressure, multi-hit detection and saturating performance counters. It sits between the load unit and the dcache tag array, TLB and MSHR file.

## Interface
- WAY_NUM, 4, associativity (1..8)
- VADDR_WIDTH, 39, virtual address bits
- PADDR_WIDTH, 36, physical address bits
- IDX_HIGH, 11, top set-index bit
- IDX_LOW, 6, bottom set-index bit; TAGARRAY_ADDR_WIDTH = IDX_HIGH-IDX_LOW+1
- ROBID_WIDTH, 7, ROB id width (includes wrap bit)
- CNT_WIDTH, 16, perf counter width
- Derived: TAG_WIDTH = PADDR_WIDTH-IDX_HIGH-1; TAGARRAY_DATA_WIDTH = TAG_WIDTH+1 (MSB = line valid)
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  kill all in-flight loads
- req_valid / req_ready  in/out  1  load request handshake
- req_vaddr  in  VADDR_WIDTH  load virtual address
- req_robid  in  ROBID_WIDTH  load ROB id
- fromtlb_valid, fromtlb_hit  in  1  TLB response for the S1 load
- fromtlb_paddr  in  PADDR_WIDTH  translated address
- tagarray_rd_en  out  1  tag read strobe
- tagarray_rd_idx  out  TAGARRAY_ADDR_WIDTH  set index
- tagarray_rd_data  in  WAY_NUM*TAGARRAY_DATA_WIDTH  way i at [i*TAGARRAY_DATA_WIDTH +: TAGARRAY_DATA_WIDTH]; valid one cycle after rd_en
- mshr_allocate_valid / mshr_allocate_ready  out/in  1  miss allocation handshake
- mshr_allocate_paddr  out  PADDR_WIDTH  line address, bits [IDX_LOW-1:0] zeroed
- mshr_allocate_robid  out  ROBID_WIDTH
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_robid  out  ROBID_WIDTH
- resp_hit, resp_miss, resp_replay, resp_multihit  out  1  outcome flags
- resp_way  out  max(1,$clog2(WAY_NUM))  hit way
- perf_hit_cnt, perf_miss_cnt  out  CNT_WIDTH  saturating counters

## Operation
- S0: handshake when req_valid & req_ready. req_ready = ~flush & (~s1_valid | s1_adv).
  - tagarray_rd_en = req_valid & req_ready.
  - tagarray_rd_idx = req_vaddr[IDX_HIGH:IDX_LOW], driven every cycle.
  - Accepted vaddr and robid are registered into S1.
- S1, first cycle only (s1_fresh = 1):
  - Sample TLB and tag data.
  - way i matches when data_i[MSB] & data_i[TAG_WIDTH-1:0] == paddr[PADDR_WIDTH-1:IDX_HIGH+1].
  - replay = ~fromtlb_valid | ~fromtlb_hit. If replay is set, hit and miss are forced to 0.
  - hit = |match (when not replay); miss = ~hit & ~replay; multihit = popcount(match) > 1.
  - Chosen way = lowest-index match.
- S1 result buffering:
  - Results and paddr are latched into S1 hold registers and s1_fresh clears.
  - While S1 is stalled, the held results are used. Tag and TLB inputs are ignored after the first cycle.
- s1_adv = s1_valid & (~s2_valid | s2_adv).
- S2:
  - hit or replay: s2_adv = 1, resp_valid = 1 that cycle.
  - miss: mshr_allocate_valid = s2_valid & s2_miss & ~flush. s2_adv = mshr_allocate_valid & mshr_allocate_ready. resp_valid (resp_miss = 1) pulses on the handshake cycle only.
- Response flags are mutually exclusive among hit, miss and replay. resp_multihit may accompany resp_hit only. resp_way = 0 unless resp_hit.
- Counters:
  - perf_hit_cnt increments on a resp_hit pulse.
  - perf_miss_cnt increments on a resp_miss pulse.
  - Both saturate at all-ones. Flush does not clear them.
- Flush:
  - Next edge clears s1_valid and s2_valid.
  - During the flush cycle, resp_valid and mshr_allocate_valid are forced to 0 and no request is accepted.

## Timing
- Reset values:
  - req_ready = 1; all resp_* = 0.
  - mshr_allocate_valid = 0; perf counters = 0.
  - Stage valids = 0; s1_fresh = 0.
- Request accepted in cycle T:
  - Tag read in T; TLB and tag data in T+1.
  - Hit or replay response in T+2.
  - Miss response no earlier than T+2, on the MSHR handshake.
- Throughput is one load per cycle while there are no misses.
- A miss stalled in S2 holds S1. req_ready drops once S1 is occupied and cannot advance.
- mshr_allocate_paddr and mshr_allocate_robid are stable while valid is high and ready is low.
- A flush coinciding with ready = 1 loses the allocation; the MSHR must not see valid.
- Reset mid-stall drops all state asynchronously. Outputs return to reset values immediately.

## Test plan
- WAY_NUM=4, set 5 way 2 valid with tag 0x1234, paddr tag matches, TLB hit → T+2: resp_hit=1, resp_way=2, perf_hit_cnt=1.
- Same set, no way matches, mshr_allocate_ready low for 3 cycles:
  - mshr_allocate_valid is held with stable paddr (line-aligned) and robid.
  - A back-to-back second load waits in S1; req_ready=0.
  - The second load resolves correctly after the handshake, using its held compare result.
- fromtlb_hit=0 → T+2: resp_replay=1; no MSHR request; counters unchanged.
- Ways 1 and 3 both match → resp_hit=1, resp_way=1, resp_multihit=1.
- Flush asserted while a miss is pending in S2 and a load is in S1 → both dropped; no resp_valid and no MSHR valid afterwards; req_ready=1 in the next cycle.
- CNT_WIDTH=2, 5 consecutive hits → perf_hit_cnt stops at 3. reset_n low mid-stall → all outputs return to reset values without a clock edge.
